// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush controller for a 5-stage pipeline. Decides which
//                pipeline registers load or take a bubble from load-use
//                hazards, MEM-stage redirects, memory handshakes and debug
//                halt; keeps saturating stall/flush counters and a sticky
//                data-memory timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             mem_branch_taken_i,
    input  logic             mem_jump_i,
    input  logic             imem_ready_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    input  logic             dbg_halt_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_flush_o,
    output logic             pc_sel_redirect_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o,
    output logic             err_mem_timeout_o
);

    localparam int              WC_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              err_q, err_d;

    logic mstall, redir, lu, fstall;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, redirect, redir_applied;

    assign mstall = dmem_req_i & ~dmem_ready_i;
    assign redir  = mem_branch_taken_i | mem_jump_i;
    assign lu     = ex_memread_i && (ex_rd_i != 5'd0) &&
                    ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
    assign fstall = ~imem_ready_i;

    // Priority-ordered enable/flush decode; RUN and MEM_WAIT share it since
    // mstall already dominates while an access is outstanding.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_fl      = 1'b0;
        id_ex_fl      = 1'b0;
        ex_mem_fl     = 1'b0;
        mem_wb_fl     = 1'b0;
        redirect      = 1'b0;
        redir_applied = 1'b0;
        if (state_q == S_HALT) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (mstall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_fl = 1'b1;
        end else if (redir) begin
            redirect      = 1'b1;
            if_id_fl      = 1'b1;
            id_ex_fl      = 1'b1;
            ex_mem_fl     = 1'b1;
            redir_applied = 1'b1;
        end else if (lu) begin
            // Holding IF/ID also absorbs any concurrent fetch stall.
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_fl = 1'b1;
        end else if (fstall) begin
            pc_en    = 1'b0;
            if_id_fl = 1'b1;
        end
    end

    // While in reset every register loads a bubble so the pipe comes up clean.
    always_comb begin
        pc_en_o           = pc_en;
        if_id_en_o        = if_id_en;
        id_ex_en_o        = id_ex_en;
        ex_mem_en_o       = ex_mem_en;
        mem_wb_en_o       = mem_wb_en;
        if_id_flush_o     = if_id_fl;
        id_ex_flush_o     = id_ex_fl;
        ex_mem_flush_o    = ex_mem_fl;
        mem_wb_flush_o    = mem_wb_fl;
        pc_sel_redirect_o = redirect;
        if (rst) begin
            pc_en_o           = 1'b1;
            if_id_en_o        = 1'b1;
            id_ex_en_o        = 1'b1;
            ex_mem_en_o       = 1'b1;
            mem_wb_en_o       = 1'b1;
            if_id_flush_o     = 1'b1;
            id_ex_flush_o     = 1'b1;
            ex_mem_flush_o    = 1'b1;
            mem_wb_flush_o    = 1'b1;
            pc_sel_redirect_o = 1'b0;
        end
    end

    // Next state, wait counter, sticky timeout and saturating perf counters.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_RUN: begin
                if (mstall) begin
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = '0;
                end else if (dbg_halt_i) begin
                    state_d = S_HALT;
                end
            end
            S_MEM_WAIT: begin
                if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
                if (!mstall) state_d = dbg_halt_i ? S_HALT : S_RUN;
            end
            S_HALT: begin
                if (!dbg_halt_i) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
        err_d   = err_q | ((state_q == S_MEM_WAIT) && (wait_cnt_d == WAIT_MAX));
        stall_d = stall_q;
        if (!pc_en && (state_q != S_HALT) && (stall_q != '1)) stall_d = stall_q + 1'b1;
        flush_d = flush_q;
        if (redir_applied && (flush_q != '1)) flush_d = flush_q + 1'b1;
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            err_q      <= err_d;
        end
    end

    assign halted_o          = (state_q == S_HALT);
    assign stall_cycles_o    = stall_q;
    assign flush_events_o    = flush_q;
    assign err_mem_timeout_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl
//                (CNT_W=4, MEM_TIMEOUT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_memread;
    logic mem_branch_taken, mem_jump, imem_ready, dmem_req, dmem_ready, dbg_halt;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic pc_sel_redirect, halted, err_mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_uses_rs1_i     (id_uses_rs1),
        .id_uses_rs2_i     (id_uses_rs2),
        .ex_memread_i      (ex_memread),
        .ex_rd_i           (ex_rd),
        .mem_branch_taken_i(mem_branch_taken),
        .mem_jump_i        (mem_jump),
        .imem_ready_i      (imem_ready),
        .dmem_req_i        (dmem_req),
        .dmem_ready_i      (dmem_ready),
        .dbg_halt_i        (dbg_halt),
        .pc_en_o           (pc_en),
        .if_id_en_o        (if_id_en),
        .id_ex_en_o        (id_ex_en),
        .ex_mem_en_o       (ex_mem_en),
        .mem_wb_en_o       (mem_wb_en),
        .if_id_flush_o     (if_id_flush),
        .id_ex_flush_o     (id_ex_flush),
        .ex_mem_flush_o    (ex_mem_flush),
        .mem_wb_flush_o    (mem_wb_flush),
        .pc_sel_redirect_o (pc_sel_redirect),
        .halted_o          (halted),
        .stall_cycles_o    (stall_cycles),
        .flush_events_o    (flush_events),
        .err_mem_timeout_o (err_mem_timeout)
    );

    always #5 clk = ~clk;

    logic [4:0] en_v;
    logic [3:0] fl_v;
    assign en_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl_v = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Combinational outputs: enables, flushes, redirect select.
    task automatic chk_ctl(input string tag, input logic [4:0] en, input logic [3:0] fl,
                           input logic rd);
        chk({tag, "_en"}, 32'(en_v), 32'(en));
        chk({tag, "_fl"}, 32'(fl_v), 32'(fl));
        chk({tag, "_rd"}, 32'(pc_sel_redirect), 32'(rd));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_memread = 1'b0;
        mem_branch_taken = 1'b0; mem_jump = 1'b0; imem_ready = 1'b1;
        dmem_req = 1'b0; dmem_ready = 1'b0; dbg_halt = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        mem_branch_taken = 1'b1;
        #1;
        chk_ctl("in_reset", 5'b11111, 4'b1111, 1'b0);
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("rst_stall", 32'(stall_cycles), 0);
        chk("rst_flush", 32'(flush_events), 0);
        chk("rst_err", 32'(err_mem_timeout), 0);
        chk("rst_halted", 32'(halted), 0);
        chk_ctl("run_idle", 5'b11111, 4'b0000, 1'b0);

        // Load-use on rs2 = x5: one bubble.
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        #1;
        chk_ctl("lu", 5'b00111, 4'b0100, 1'b0);
        step();
        chk("lu_stall", 32'(stall_cycles), 1);
        ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        chk_ctl("lu_x0", 5'b11111, 4'b0000, 1'b0);
        step();
        chk("lu_x0_stall", 32'(stall_cycles), 1);

        // Taken branch beats fetch stall and load-use.
        ex_rd = 5'd5; id_rs2 = 5'd5; imem_ready = 1'b0; mem_branch_taken = 1'b1;
        #1;
        chk_ctl("redir", 5'b11111, 4'b1110, 1'b1);
        step();
        chk("redir_flush", 32'(flush_events), 1);
        chk("redir_stall", 32'(stall_cycles), 1);
        idle();

        // Fetch stall alone.
        imem_ready = 1'b0;
        #1;
        chk_ctl("fstall", 5'b01111, 4'b1000, 1'b0);
        step();
        chk("fstall_stall", 32'(stall_cycles), 2);
        idle();

        // Data stall for 3 cycles, completes on the 4th.
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_ctl("mstall3", 5'b00001, 4'b0001, 1'b0);
            step();
        end
        dmem_ready = 1'b1;
        #1;
        chk_ctl("mstall3_done", 5'b11111, 4'b0000, 1'b0);
        step();
        chk("mstall3_stall", 32'(stall_cycles), 5);
        chk("mstall3_halted", 32'(halted), 0);
        chk("mstall3_err", 32'(err_mem_timeout), 0);
        idle();

        // Timeout: ready low for 6 cycles.
        dmem_req = 1'b1;
        step(); step(); step();
        chk("to_early_err", 32'(err_mem_timeout), 0);
        step(); step();
        chk("to_err", 32'(err_mem_timeout), 1);
        #1;
        chk_ctl("to_still_stall", 5'b00001, 4'b0001, 1'b0);
        step();
        dmem_ready = 1'b1;
        #1;
        chk_ctl("to_done", 5'b11111, 4'b0000, 1'b0);
        step();
        idle();
        chk("to_sticky", 32'(err_mem_timeout), 1);
        chk("to_stall", 32'(stall_cycles), 11);

        // Halt requested during MEM_WAIT: access completes first.
        dmem_req = 1'b1;
        step();
        dbg_halt = 1'b1;
        #1;
        chk_ctl("h_mw", 5'b00001, 4'b0001, 1'b0);
        step();
        chk("h_mw_halted", 32'(halted), 0);
        dmem_ready = 1'b1;
        #1;
        chk_ctl("h_done", 5'b11111, 4'b0000, 1'b0);
        step();
        chk("h_halted", 32'(halted), 1);
        dmem_req = 1'b0; dmem_ready = 1'b0;
        mem_jump = 1'b1;
        #1;
        chk_ctl("h_jump_ignored", 5'b00000, 4'b0000, 1'b0);
        step();
        chk("h_flush", 32'(flush_events), 1);
        chk("h_stall", 32'(stall_cycles), 13);
        dbg_halt = 1'b0;
        #1;
        chk_ctl("h_release", 5'b00000, 4'b0000, 1'b0);
        step();
        chk("h_resumed", 32'(halted), 0);
        chk_ctl("h_jump_acts", 5'b11111, 4'b1110, 1'b1);
        step();
        chk("h_jump_flush", 32'(flush_events), 2);
        idle();

        // Stall counter saturation.
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("sat_stall", 32'(stall_cycles), 15);
        idle();

        // Reset in the middle of MEM_WAIT.
        dmem_req = 1'b1;
        step(); step();
        rst = 1'b1;
        #1;
        chk_ctl("rst_mw", 5'b11111, 4'b1111, 1'b0);
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("rmw_stall", 32'(stall_cycles), 0);
        chk("rmw_flush", 32'(flush_events), 0);
        chk("rmw_err", 32'(err_mem_timeout), 0);
        chk_ctl("rmw_run", 5'b11111, 4'b0000, 1'b0);

        // Halt taken while a fetch stall is present, then reset from HALT.
        dbg_halt = 1'b1; imem_ready = 1'b0;
        #1;
        chk_ctl("halt_entry", 5'b01111, 4'b1000, 1'b0);
        step();
        chk("halt_entry_halted", 32'(halted), 1);
        chk("halt_entry_stall", 32'(stall_cycles), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("rh_halted", 32'(halted), 0);
        chk_ctl("rh_run", 5'b11111, 4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
